// File: rtl/interlock_timer_if.sv
// rtl/interlock_timer_if.sv - start/done bundle between the interlock FSM and its timer stage
interface interlock_timer_if;
  logic       wait_start;
  logic       fill_start;
  logic       drain_start;
  logic       wait_done;
  logic       fill_done;
  logic       drain_done;
  logic [3:0] min_left;
  logic [1:0] active_ch;
  logic       busy;

  modport master (
    output wait_start, fill_start, drain_start,
    input  wait_done, fill_done, drain_done, min_left, active_ch, busy
  );

  modport slave (
    input  wait_start, fill_start, drain_start,
    output wait_done, fill_done, drain_done, min_left, active_ch, busy
  );
endinterface

// File: rtl/interlock_timer.sv
// rtl/interlock_timer.sv - shared minute timer serving the wait/fill/drain interlock channels
// Optional INTERLOCK_TIMER_FAST_EN forces 4 cycles per minute for simulation and board demos.
module interlock_timer #(
  parameter int CYCLES_PER_MIN = 60,
  parameter int WAIT_MIN       = 5,
  parameter int FILL_MIN       = 7,
  parameter int DRAIN_MIN      = 8,
  parameter int PS_W           = 26
) (
  input  logic              clk,
  input  logic              reset,
  interlock_timer_if.slave  bus
);

`ifdef INTERLOCK_TIMER_FAST_EN
  localparam int EFF_CPM = 4;
`else
  localparam int EFF_CPM = CYCLES_PER_MIN;
`endif

  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(EFF_CPM - 1);
  localparam logic [3:0]      WAIT_DUR  = 4'(WAIT_MIN);
  localparam logic [3:0]      FILL_DUR  = 4'(FILL_MIN);
  localparam logic [3:0]      DRAIN_DUR = 4'(DRAIN_MIN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [3:0]      min_q, min_d;
  logic [1:0]      ch_q, ch_d;
  logic [2:0]      done_q, done_d;
  logic            busy_q, busy_d;

  logic [1:0]      req_ch;
  logic [3:0]      req_dur;
  logic            act_start;
  logic            wrap;

  function automatic logic [2:0] ch_onehot(input logic [1:0] ch);
    case (ch)
      2'd1:    ch_onehot = 3'b001;
      2'd2:    ch_onehot = 3'b010;
      2'd3:    ch_onehot = 3'b100;
      default: ch_onehot = 3'b000;
    endcase
  endfunction

  // Request arbitration (wait > fill > drain) and the live start of the latched channel
  always_comb begin
    req_ch  = 2'd0;
    req_dur = 4'd0;
    if (bus.wait_start) begin
      req_ch  = 2'd1;
      req_dur = WAIT_DUR;
    end else if (bus.fill_start) begin
      req_ch  = 2'd2;
      req_dur = FILL_DUR;
    end else if (bus.drain_start) begin
      req_ch  = 2'd3;
      req_dur = DRAIN_DUR;
    end
    case (ch_q)
      2'd1:    act_start = bus.wait_start;
      2'd2:    act_start = bus.fill_start;
      2'd3:    act_start = bus.drain_start;
      default: act_start = 1'b0;
    endcase
    wrap = (ps_q == PS_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_ch != 2'd0) state_d = (req_dur == 4'd0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (!act_start)                    state_d = S_IDLE;
        else if (wrap && (min_q <= 4'd1)) state_d = S_DONE;
      end
      S_DONE: if (!act_start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; an abort always wins over a minute wrap
  always_comb begin
    ps_d   = ps_q;
    min_d  = min_q;
    ch_d   = ch_q;
    done_d = done_q;
    busy_d = busy_q;
    case (state_q)
      S_IDLE: begin
        if (req_ch != 2'd0) begin
          ch_d   = req_ch;
          min_d  = req_dur;
          ps_d   = '0;
          busy_d = 1'b1;
          done_d = (req_dur == 4'd0) ? ch_onehot(req_ch) : 3'b000;
        end
      end
      S_RUN: begin
        if (!act_start) begin
          ch_d   = 2'd0;
          min_d  = 4'd0;
          ps_d   = '0;
          busy_d = 1'b0;
          done_d = 3'b000;
        end else if (wrap) begin
          ps_d = '0;
          if (min_q <= 4'd1) begin
            min_d  = 4'd0;
            done_d = ch_onehot(ch_q);
          end else begin
            min_d = min_q - 4'd1;
          end
        end else begin
          ps_d = ps_q + PS_W'(1);
        end
      end
      S_DONE: begin
        if (!act_start) begin
          ch_d   = 2'd0;
          min_d  = 4'd0;
          ps_d   = '0;
          busy_d = 1'b0;
          done_d = 3'b000;
        end
      end
      default: begin
        ch_d   = 2'd0;
        min_d  = 4'd0;
        ps_d   = '0;
        busy_d = 1'b0;
        done_d = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q   <= '0;
      min_q  <= 4'd0;
      ch_q   <= 2'd0;
      done_q <= 3'b000;
      busy_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      min_q  <= min_d;
      ch_q   <= ch_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign bus.wait_done  = done_q[0];
  assign bus.fill_done  = done_q[1];
  assign bus.drain_done = done_q[2];
  assign bus.min_left   = min_q;
  assign bus.active_ch  = ch_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_interlock_timer.sv
// tb/tb_interlock_timer.sv - scoreboard bench for interlock_timer at 4 cycles per minute
module tb_interlock_timer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  interlock_timer_if bus();

  interlock_timer #(
    .CYCLES_PER_MIN(4),
    .WAIT_MIN(5),
    .FILL_MIN(7),
    .DRAIN_MIN(8),
    .PS_W(26)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] ch;
    int         at;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] onehot(input logic [1:0] ch);
    case (ch)
      2'd1:    onehot = 3'b001;
      2'd2:    onehot = 3'b010;
      2'd3:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // Monitor: every rising done is matched against the next expected completion
  logic [2:0] prev_done = 3'b000;
  logic [2:0] cur_done;
  logic [2:0] rise;
  exp_t       e;
  always @(negedge clk) begin
    cur_done = {bus.drain_done, bus.fill_done, bus.wait_done};
    rise = cur_done & ~prev_done;
    if (rise != 3'b000) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%b expected=none (cycle %0d)", rise, cyc);
      end else begin
        e = sb.pop_front();
        check("done_channel", 32'(rise), 32'(onehot(e.ch)));
        check("done_cycle", cyc, e.at);
      end
    end
    if (cur_done != 3'b000) check("done_exclusive", $countones(cur_done), 1);
    prev_done = cur_done;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_any_done(input int limit);
    int k = 0;
    while (!(bus.wait_done || bus.fill_done || bus.drain_done) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", 32'(bus.wait_done || bus.fill_done || bus.drain_done), 1);
  endtask

  task automatic check_idle(input string name);
    check({name, "_dones"}, 32'({bus.drain_done, bus.fill_done, bus.wait_done}), 0);
    check({name, "_min_left"}, 32'(bus.min_left), 0);
    check({name, "_active_ch"}, 32'(bus.active_ch), 0);
    check({name, "_busy"}, 32'(bus.busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bus.wait_start  = 1'b0;
    bus.fill_start  = 1'b0;
    bus.drain_start = 1'b0;
    reset = 1'b1;
    step(3);
    check_idle("reset");
    reset = 1'b0;
    step(1);

    // Wait channel: 5 minutes, countdown visible every 4 cycles
    bus.wait_start = 1'b1;
    sb.push_back('{2'd1, cyc + 21});
    step(1);
    check("wait_active_ch", 32'(bus.active_ch), 1);
    check("wait_busy", 32'(bus.busy), 1);
    check("wait_min_5", 32'(bus.min_left), 5);
    for (int k = 1; k <= 4; k++) begin
      step(4);
      check("wait_min_step", 32'(bus.min_left), 32'(5 - k));
    end
    wait_any_done(10);
    check("wait_min_0", 32'(bus.min_left), 0);
    check("wait_done_level", 32'(bus.wait_done), 1);
    step(2);
    check("wait_done_held", 32'(bus.wait_done), 1);
    bus.wait_start = 1'b0;
    step(1);
    check_idle("wait_release");

    // Fill channel
    bus.fill_start = 1'b1;
    sb.push_back('{2'd2, cyc + 29});
    wait_any_done(40);
    check("fill_done_level", 32'(bus.fill_done), 1);
    bus.fill_start = 1'b0;
    step(1);
    check_idle("fill_release");

    // Drain channel
    bus.drain_start = 1'b1;
    sb.push_back('{2'd3, cyc + 33});
    wait_any_done(40);
    check("drain_done_only", 32'({bus.drain_done, bus.fill_done, bus.wait_done}), 32'b100);
    bus.drain_start = 1'b0;
    step(1);
    check_idle("drain_release");

    // Fill aborted after 10 cycles: no done may ever appear
    bus.fill_start = 1'b1;
    step(10);
    check("abort_busy_before", 32'(bus.busy), 1);
    bus.fill_start = 1'b0;
    step(1);
    check_idle("abort");
    step(40);
    check("abort_no_fill_done", 32'(bus.fill_done), 0);

    // Simultaneous wait+drain: wait first, drain one edge after DONE->IDLE
    bus.wait_start  = 1'b1;
    bus.drain_start = 1'b1;
    sb.push_back('{2'd1, cyc + 21});
    step(1);
    check("prio_active_wait", 32'(bus.active_ch), 1);
    check("prio_min_5", 32'(bus.min_left), 5);
    wait_any_done(30);
    check("prio_wait_done", 32'(bus.wait_done), 1);
    bus.wait_start = 1'b0;
    sb.push_back('{2'd3, cyc + 34});
    step(1);
    check_idle("prio_gap");
    step(1);
    check("prio_active_drain", 32'(bus.active_ch), 3);
    check("prio_min_8", 32'(bus.min_left), 8);
    wait_any_done(40);
    bus.drain_start = 1'b0;
    step(1);
    check_idle("prio_release");

    // Reset in RUN at min_left=3, then a fresh full-length wait
    bus.wait_start = 1'b1;
    for (int k = 0; k < 20 && bus.min_left != 4'd3; k++) step(1);
    check("mid_min_3", 32'(bus.min_left), 3);
    reset = 1'b1;
    step(1);
    check_idle("mid_reset");
    reset = 1'b0;
    sb.push_back('{2'd1, cyc + 21});
    step(1);
    check("restart_min_5", 32'(bus.min_left), 5);
    wait_any_done(30);
    bus.wait_start = 1'b0;
    step(1);
    check_idle("restart_release");

    step(2);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
